// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over valid/ready,
// with programmable wait states and byte/half/word access with load extension.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, commit;

    logic        we_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        a_we;
    logic [2:0]  a_type;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_err;
    logic [IW-1:0] idx;
    logic [31:0] rd_word;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        err_q;

    function automatic logic addr_err(input logic [2:0] t, input logic [31:0] a);
        logic e;
        e = 1'b0;
        case (t)
            3'b000:         e = (a[1:0] != 2'b00);
            3'b001, 3'b010: e = a[0];
            3'b011, 3'b100: e = 1'b0;
            default:        e = 1'b1;
        endcase
        if ({1'b0, a} >= LIMIT)
            e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  t,
                                                 input logic [1:0]  off);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = off[1] ? word[31:16] : word[15:0];
        b = word[{off, 3'b000} +: 8];
        case (t)
            3'b000:  r = word;
            3'b001:  r = {16'h0000, h};
            3'b010:  r = {{16{h[15]}}, h};
            3'b011:  r = {24'h000000, b};
            3'b100:  r = {{24{b[7]}}, b};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Merge right-aligned store data into the old word, keeping untouched lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [2:0]  t,
                                                input logic [1:0]  off,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (t)
            3'b000: r = wd;
            3'b001, 3'b010: begin
                if (off[1])
                    r[31:16] = wd[15:0];
                else
                    r[15:0]  = wd[15:0];
            end
            3'b011, 3'b100: r[{off, 3'b000} +: 8] = wd[7:0];
            default: r = old;
        endcase
        return r;
    endfunction

    // In IDLE the live request is used directly so a zero-wait access commits on the accept edge.
    always_comb begin
        if (state == S_IDLE) begin
            a_we    = req_we;
            a_type  = req_type;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end else begin
            a_we    = we_q;
            a_type  = type_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
        a_err   = addr_err(a_type, a_addr);
        idx     = a_addr[IW+1:2];
        rd_word = mem[idx];
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        commit    = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        cnt_nxt   = 4'(WAIT_CYCLES);
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            type_q  <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rdata_q <= (a_err || a_we) ? 32'h0 : load_extract(rd_word, a_type, a_addr[1:0]);
                err_q   <= a_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'h0;
        end else if (commit && a_we && !a_err) begin
            mem[idx] <= store_merge(rd_word, a_type, a_addr[1:0], a_wdata);
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked against
// a byte-array reference memory, plus directed literal expectations.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int NB    = DEPTH * 4;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_type   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  ref_mem [2][NB];
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NB; i++)
                ref_mem[d][i] = 8'h00;
    endfunction

    // Byte-addressed reference: size from type, alignment by modulo, range by byte count.
    function automatic void model_access(input int d, input logic we, input logic [2:0] t,
                                         input logic [31:0] a, input logic [31:0] wd);
        int     size;
        longint v;
        case (t)
            3'd0:       size = 4;
            3'd1, 3'd2: size = 2;
            3'd3, 3'd4: size = 1;
            default:    size = 0;
        endcase
        exp_err[d]   = (size == 0) || (longint'(a) >= NB) || ((int'(a[1:0]) % size) != 0);
        exp_rdata[d] = 32'h0;
        if (!exp_err[d]) begin
            if (we) begin
                for (int i = 0; i < size; i++)
                    ref_mem[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++)
                    v = v | (longint'(ref_mem[d][int'(a) + i]) << (8*i));
                if ((t == 3'd2 || t == 3'd4) && v[8*size-1])
                    v = v | ((-64'sd1) << (8*size));
                exp_rdata[d] = v[31:0];
            end
        end
    endfunction

    task automatic do_req(input int d, input logic we, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          input bit lit, input logic [31:0] lit_rdata, input logic lit_err);
        int n;
        int lat;
        lat = (d == 0) ? W0 + 1 : W1 + 1;
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_type[d]  = t;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        model_access(d, we, t, a, wd);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        while (!resp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, lat);
        if (!resp_valid[d]) return;
        if (lit) begin
            check("lit_rdata", resp_rdata[d], lit_rdata);
            check("lit_err", {31'b0, resp_err[d]}, {31'b0, lit_err});
        end
        for (int h = 0; h < hold; h++) begin
            req_valid[d] = (h == 0);
            req_we[d]    = 1'b1;
            req_type[d]  = 3'd0;
            req_addr[d]  = 32'h10;
            req_wdata[d] = 32'hDEADBEEF;
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid[d]}, 32'd1);
            check("hold_ready", {31'b0, req_ready[d]}, 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check("resp_drop", {31'b0, resp_valid[d]}, 32'd0);
        check("back_idle", {31'b0, req_ready[d]}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int d = 0; d < 2; d++) begin
                check("exclusive", {31'b0, resp_valid[d] & req_ready[d]}, 32'd0);
                if (resp_valid[d] === 1'b1) begin
                    check("rdata", resp_rdata[d], exp_rdata[d]);
                    check("err", {31'b0, resp_err[d]}, {31'b0, exp_err[d]});
                end
            end
        end
    end

    initial begin
        logic [2:0]  rt;
        logic [31:0] ra;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_type[d] = 3'd0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
            exp_rdata[d] = 32'h0; exp_err[d] = 1'b0;
        end
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", {31'b0, req_ready[d]}, 32'd1);
            check("rst_resp_valid", {31'b0, resp_valid[d]}, 32'd0);
            check("rst_rdata", resp_rdata[d], 32'h0);
            check("rst_err", {31'b0, resp_err[d]}, 32'd0);
        end
        reset = 1'b0;

        do_req(0, 1, 3'd0, 32'h10, 32'h12345678, 0, 1, 32'h0, 1'b0);
        do_req(0, 0, 3'd0, 32'h10, 32'h0, 0, 1, 32'h12345678, 1'b0);
        do_req(0, 1, 3'd3, 32'h11, 32'h000000AB, 0, 1, 32'h0, 1'b0);
        do_req(0, 0, 3'd0, 32'h10, 32'h0, 0, 1, 32'h1234AB78, 1'b0);
        do_req(0, 0, 3'd4, 32'h11, 32'h0, 0, 1, 32'hFFFFFFAB, 1'b0);
        do_req(0, 0, 3'd3, 32'h11, 32'h0, 0, 1, 32'h000000AB, 1'b0);
        do_req(0, 0, 3'd2, 32'h12, 32'h0, 0, 1, 32'h00001234, 1'b0);
        do_req(0, 1, 3'd1, 32'h12, 32'h00008001, 0, 1, 32'h0, 1'b0);
        do_req(0, 0, 3'd2, 32'h12, 32'h0, 0, 1, 32'hFFFF8001, 1'b0);
        do_req(0, 0, 3'd0, 32'h13, 32'h0, 0, 1, 32'h0, 1'b1);
        do_req(0, 0, 3'd1, 32'h11, 32'h0, 0, 1, 32'h0, 1'b1);
        do_req(0, 0, 3'd7, 32'h10, 32'h0, 0, 1, 32'h0, 1'b1);
        do_req(0, 1, 3'd0, NB, 32'hFFFFFFFF, 0, 1, 32'h0, 1'b1);
        do_req(0, 1, 3'd7, 32'h10, 32'hFFFFFFFF, 0, 1, 32'h0, 1'b1);
        do_req(0, 1, 3'd1, 32'h11, 32'hFFFFFFFF, 0, 1, 32'h0, 1'b1);
        do_req(0, 0, 3'd0, 32'h10, 32'h0, 0, 1, 32'h8001AB78, 1'b0);
        do_req(0, 0, 3'd0, 32'h10, 32'h0, 5, 1, 32'h8001AB78, 1'b0);
        do_req(0, 0, 3'd0, 32'h10, 32'h0, 0, 1, 32'h8001AB78, 1'b0);

        // Reset while a store sits in its wait states.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_type[0] = 3'd0;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h55AA55AA;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ready", {31'b0, req_ready[0]}, 32'd1);
        check("async_rst_valid", {31'b0, resp_valid[0]}, 32'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        do_req(0, 0, 3'd0, 32'h20, 32'h0, 0, 1, 32'h0, 1'b0);
        do_req(0, 0, 3'd0, 32'h10, 32'h0, 0, 1, 32'h0, 1'b0);

        do_req(1, 1, 3'd0, 32'h8, 32'hCAFEF00D, 0, 1, 32'h0, 1'b0);
        do_req(1, 0, 3'd0, 32'h8, 32'h0, 0, 1, 32'hCAFEF00D, 1'b0);
        do_req(1, 0, 3'd4, 32'hB, 32'h0, 2, 1, 32'hFFFFFFCA, 1'b0);
        do_req(1, 0, 3'd1, 32'hA, 32'h0, 0, 1, 32'h0000CAFE, 1'b0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0)
                rt = 3'($urandom_range(5, 7));
            else
                rt = 3'($urandom_range(0, 4));
            case ($urandom_range(0, 19))
                0:       ra = $urandom;
                1:       ra = NB + $urandom_range(0, 7);
                default: begin
                    ra = $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
                end
            endcase
            do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rt, ra, $urandom,
                   int'($urandom_range(0, 2)), 0, 32'h0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor data-memory port. Serves one load/store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns read data or a completion and error flag.
- Performs byte, halfword and word access with sign or zero extension on loads.
- Replaces the single-cycle data memory so the multi-cycle control unit can be exercised against a slow memory.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (byte address range 0 to DEPTH*4-1).
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 to 15).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_type  input  3  access type (encoding below)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  response present
- resp_ready  input  1  requester takes the response
- resp_rdata  output  32  load result, extended; 0 for stores and errors
- resp_err  output  1  request was misaligned, out of range, or had an illegal type

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Wait counter = 0. All memory words = 0.
  - Reset mid-transaction discards the transaction; a pending store that has not committed is not written.
- req_type encoding:
  - 000 = word, 001 = half unsigned, 010 = half signed, 011 = byte unsigned, 100 = byte signed.
  - 101, 110 and 111 are illegal.
  - For stores, 001/010 are treated as half and 011/100 as byte.
- Byte lanes are little-endian: byte at addr[1:0]=k lives in word bits [8k+7:8k]. Word index = addr[31:2].
- Error conditions:
  - word access with addr[1:0]!=0;
  - half access with addr[0]!=0;
  - addr >= DEPTH*4;
  - illegal type.
  - On error: no memory write, resp_rdata=0, resp_err=1.
- FSM states:
  - IDLE: req_ready=1. If req_valid is high at a clock edge, latch we/type/addr/wdata and compute the error flag.
    - If WAIT_CYCLES=0, go to RESP. Otherwise load counter=WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle. On the edge where counter==1, go to RESP. req_valid is ignored.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err stay stable while resp_ready=0. When resp_ready=1 at an edge, go to IDLE.
    - A new request can be accepted no earlier than the cycle after leaving RESP (no bypass).
- Commit timing:
  - The memory write and the read-data capture happen on the same edge that enters RESP.
  - A load that follows a store therefore sees the store's data.
  - A store updates only the addressed byte(s); the other bytes are preserved.
- Latency: acceptance at edge T makes resp_valid=1 in the cycle after edge T+WAIT_CYCLES. With default 2, resp_valid is high 3 cycles after the request cycle.
- Load extension: half signed or byte signed replicates bit 15 or bit 7 into the upper bits; the unsigned variants zero-fill.
- resp_valid and req_ready are never high together.

Test Plan:
- Reset, then store word 0x12345678 to 0x10 -> resp_valid high 3 cycles after the request cycle, resp_err=0. Load word 0x10 -> resp_rdata=0x12345678.
- Store byte 0xAB to 0x11 over 0x12345678, then load word 0x10 -> 0x1234AB78. Byte signed load at 0x11 -> 0xFFFFFFAB. Byte unsigned load -> 0x000000AB.
- Half signed load at 0x12 after the above -> 0x00001234. Store half 0x8001 to 0x12, then half signed load -> 0xFFFF8001.
- Word load at 0x13, half load at 0x11, type 3'b111, and word store at address DEPTH*4 -> each gives resp_err=1, resp_rdata=0, and memory is unchanged (verified by readback).
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stay stable, req_ready stays 0, and a req_valid pulse during this time is not accepted.
- Assert reset in WAIT of a store to 0x20 -> req_ready=1 and resp_valid=0 immediately; a subsequent load of 0x20 returns 0. Repeat the read-data check with WAIT_CYCLES=0 -> response in the next cycle.
